// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One neuron is serviced per enabled cycle; its results appear registered on the next cycle.
module lif_array #(
  parameter int N_NEURONS      = 8,
  parameter int WIDTH          = 8,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRAC         = 2,
  parameter int DEFAULT_THRESH = 127
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [WIDTH-1:0]             current,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]             cfg_thresh,
  output logic [N_NEURONS-1:0]         spike,
  output logic [WIDTH-1:0]             state_out,
  output logic [$clog2(N_NEURONS)-1:0] idx_out,
  output logic                         frame_done
);

  localparam int AW = $clog2(N_NEURONS);
  // A refractory counter must hold REFRAC itself; keep it at least one bit wide when REFRAC is 0.
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [WIDTH-1:0]     r_state  [N_NEURONS];
  logic [WIDTH-1:0]     r_thresh [N_NEURONS];
  logic [RW-1:0]        r_refr   [N_NEURONS];
  logic [AW-1:0]        r_ptr;
  logic [N_NEURONS-1:0] r_spike;
  logic [WIDTH-1:0]     r_state_out;
  logic [AW-1:0]        r_idx_out;
  logic                 r_frame_done;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_v;
  logic                 w_in_refr;
  logic                 w_fire;
  logic [WIDTH-1:0]     w_next_state;
  logic [RW-1:0]        w_next_refr;

  always_comb begin
    w_sum        = {1'b0, current} + {1'b0, (r_state[r_ptr] >> LEAK_SHIFT)};
    w_v          = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    w_in_refr    = (r_refr[r_ptr] != '0);
    w_fire       = 1'b0;
    w_next_state = '0;
    w_next_refr  = '0;
    if (w_in_refr) begin
      w_next_refr = r_refr[r_ptr] - RW'(1);
    end else if (w_v >= r_thresh[r_ptr]) begin
      w_fire      = 1'b1;
      w_next_refr = RW'(REFRAC);
    end else begin
      w_next_state = w_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        r_state[i]  <= '0;
        r_refr[i]   <= '0;
        r_thresh[i] <= WIDTH'(DEFAULT_THRESH);
      end
      r_ptr        <= '0;
      r_spike      <= '0;
      r_state_out  <= '0;
      r_idx_out    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= en && (r_ptr == AW'(N_NEURONS - 1));
      // Threshold write lands at the edge, so a same-cycle service still compares the old value.
      if (cfg_we) r_thresh[cfg_addr] <= cfg_thresh;
      if (en) begin
        r_state[r_ptr] <= w_next_state;
        r_refr[r_ptr]  <= w_next_refr;
        r_spike[r_ptr] <= w_fire;
        r_state_out    <= w_next_state;
        r_idx_out      <= r_ptr;
        r_ptr          <= r_ptr + AW'(1);
      end
    end
  end

  assign spike      = r_spike;
  assign state_out  = r_state_out;
  assign idx_out    = r_idx_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lif_array.sv
// Randomized and directed bench for lif_array against an integer reference model.
module tb_lif_array;

  localparam int N   = 8;
  localparam int W   = 8;
  localparam int LS  = 1;
  localparam int RF  = 2;
  localparam int DTH = 127;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  current = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_thresh = '0;
  logic [N-1:0]  spike;
  logic [W-1:0]  state_out;
  logic [AW-1:0] idx_out;
  logic          frame_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model
  int m_st [N];
  int m_th [N];
  int m_rf [N];
  int m_spk [N];
  int m_ptr, m_so, m_io, m_fd;

  lif_array #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(LS), .REFRAC(RF), .DEFAULT_THRESH(DTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh), .spike(spike),
    .state_out(state_out), .idx_out(idx_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned model_spike_vec();
    int unsigned v = 0;
    for (int i = 0; i < N; i++) if (m_spk[i] != 0) v |= (1 << i);
    return v;
  endfunction

  task automatic model_update(input bit r, input bit e, input int cur, input bit we,
                              input int a, input int th);
    int p, v;
    if (!r) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_rf[i] = 0; m_th[i] = DTH; m_spk[i] = 0; end
      m_ptr = 0; m_so = 0; m_io = 0; m_fd = 0;
      return;
    end
    m_fd = (e && m_ptr == N - 1) ? 1 : 0;
    if (e) begin
      p = m_ptr;
      if (m_rf[p] > 0) begin
        m_st[p] = 0; m_rf[p] = m_rf[p] - 1; m_spk[p] = 0;
      end else begin
        v = cur + (m_st[p] / (1 << LS));
        if (v > (1 << W) - 1) v = (1 << W) - 1;
        if (v >= m_th[p]) begin m_spk[p] = 1; m_st[p] = 0; m_rf[p] = RF; end
        else begin m_spk[p] = 0; m_st[p] = v; end
      end
      m_so = m_st[p]; m_io = p; m_ptr = (p + 1) % N;
    end
    if (we) m_th[a] = th;
  endtask

  task automatic step(input bit r, input bit e, input int cur, input bit we, input int a, input int th);
    rst_n = r; en = e; current = W'(cur); cfg_we = we; cfg_addr = AW'(a); cfg_thresh = W'(th);
    @(posedge clk);
    model_update(r, e, cur, we, a, th);
    #1;
    check("spike", spike, model_spike_vec());
    check("state_out", state_out, m_so);
    check("idx_out", idx_out, m_io);
    check("frame_done", frame_done, m_fd);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 0, 1'b0, 0, 0);
  endtask

  int exp34_st [10] = '{64, 96, 112, 120, 124, 126, 0, 0, 0, 64};
  int exp34_sp [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int fd_count;

  initial begin
    // reset state
    do_reset();
    do_reset();
    check("rst_spike", spike, 0);
    check("rst_state", state_out, 0);
    check("rst_idx", idx_out, 0);

    // constant current 64 on every neuron, watch neuron 0
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b1, 64, 1'b0, 0, 0);
      if (i % 8 == 0) begin
        check("n0_state", state_out, exp34_st[i / 8]);
        check("n0_spike", spike[0], exp34_sp[i / 8]);
      end
    end

    // saturation on neuron 2 with threshold 255
    do_reset();
    step(1'b1, 1'b0, 0, 1'b1, 2, 255);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 200, 1'b0, 0, 0);
      if (i == 2) begin check("sat_first", state_out, 200); check("sat_first_spk", spike[2], 0); end
      if (i == 10) begin check("sat_second", state_out, 0); check("sat_second_spk", spike[2], 1); end
    end

    // threshold 10 on neuron 3; others settle without firing
    do_reset();
    step(1'b1, 1'b0, 0, 1'b1, 3, 10);
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 10, 1'b0, 0, 0);
    check("others_silent", spike & 8'hF7, 0);

    // freeze with ptr=4
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom_range(0, 255), 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom_range(0, 255), 1'b0, 0, 0);
    step(1'b1, 1'b1, 30, 1'b0, 0, 0);
    check("resume_idx", idx_out, 4);

    // mid-frame reset with a concurrent threshold write
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom_range(0, 255), 1'b0, 0, 0);
    step(1'b0, 1'b1, 100, 1'b1, 0, 5);
    check("midrst_spike", spike, 0);
    check("midrst_state", state_out, 0);
    step(1'b1, 1'b1, 5, 1'b0, 0, 0);
    check("midrst_idx", idx_out, 0);
    check("midrst_nofire", spike[0], 0);

    // frame_done count over 32 cycles
    do_reset();
    fd_count = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, $urandom_range(0, 255), 1'b0, 0, 0);
      if (frame_done) fd_count++;
    end
    check("fd_count", fd_count, 4);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 255), ($urandom_range(0, 9) == 0),
           $urandom_range(0, N - 1),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N_NEURONS, default 8: number of time-multiplexed neurons; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8: membrane state, current and threshold width.
REQ-003 Parameter LEAK_SHIFT, default 1: leak applied as a right shift of the state by this amount.
REQ-004 Parameter REFRAC, default 2: services a neuron stays silent after firing; 0 disables the refractory period.
REQ-005 Parameter DEFAULT_THRESH, default 127: threshold loaded into every neuron at reset.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 en  input  1  advance; 1 = service one neuron this cycle.
REQ-009 current  input  WIDTH  unsigned input current for the neuron being serviced.
REQ-010 cfg_we  input  1  threshold write strobe.
REQ-011 cfg_addr  input  log2(N_NEURONS)  neuron index for the threshold write.
REQ-012 cfg_thresh  input  WIDTH  threshold value to write.
REQ-013 spike  output  N_NEURONS  registered spike flag, one bit per neuron.
REQ-014 state_out  output  WIDTH  state of the neuron serviced on the previous en cycle.
REQ-015 idx_out  output  log2(N_NEURONS)  index of that neuron.
REQ-016 frame_done  output  1  one-cycle pulse after neuron N_NEURONS-1 is serviced.

Function
REQ-017 The block SHALL hold per-neuron state, threshold and refractory-count registers, plus a pointer ptr.
REQ-018 On a cycle with en=1, the block SHALL service neuron ptr only, then set ptr to ptr+1, wrapping from N_NEURONS-1 to 0.
REQ-019 Service when refractory count > 0: state set to 0, count decremented, spike[ptr] set to 0.
REQ-020 Service when refractory count = 0: compute v = current + (state >> LEAK_SHIFT) at WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-021 If v >= threshold[ptr]: spike[ptr] set to 1, state set to 0 (reset-on-fire), refractory count set to REFRAC.
REQ-022 If v < threshold[ptr]: spike[ptr] set to 0, state set to v.
REQ-023 Results of a service SHALL be visible on the cycle after it (latency 1); state_out=v or 0 as stored, and idx_out=serviced index.
REQ-024 spike[i] SHALL hold its value until neuron i is next serviced.
REQ-025 frame_done SHALL be 1 on the cycle following service of neuron N_NEURONS-1, and 0 otherwise.
REQ-026 A cycle with en=0 SHALL leave ptr, state, refractory counts, spike, state_out and idx_out unchanged, with frame_done=0.
REQ-027 With cfg_we=1, threshold[cfg_addr] SHALL take cfg_thresh at the clock edge, independent of en.
REQ-028 If a write targets the neuron serviced in the same cycle, that service SHALL compare against the old threshold.
REQ-029 Threshold 0 SHALL make the neuron fire on every non-refractory service.
REQ-030 Arithmetic SHALL be unsigned and SHALL never wrap.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set:
- every state and refractory count to 0;
- every threshold to DEFAULT_THRESH;
- ptr to 0;
- spike, state_out and idx_out to 0;
- frame_done to 0.
REQ-032 Reset SHALL override en and cfg_we in the same cycle.
REQ-033 After reset, the first en cycle SHALL service neuron 0, including when reset is applied mid-frame.

Verification (defaults, REFRAC=2)
REQ-034 Constant current=64, en=1: neuron 0 state_out over successive services = 64, 96, 112, 120, 124, 126, then spike on the 7th (v=127); next two services give spike 0 and state 0; the following service gives state 64.
REQ-035 Write threshold[2]=255, current=200: neuron 2 gives 200, then saturates to 255 and spikes on its 2nd service; no wrap to 44.
REQ-036 Write threshold[3]=10, current=10: neuron 3 spikes on every non-refractory service; other neurons settle at 19/20 and never spike.
REQ-037 en=0 for 5 cycles with ptr=4: all outputs frozen and no frame_done; the next en cycle services neuron 4.
REQ-038 rst_n=0 for one cycle at ptr=5 with cfg_we=1: all outputs 0, the write is discarded, thresholds are 127, and the next en cycle gives idx_out=0.
REQ-039 32 consecutive en cycles: exactly 4 frame_done pulses, each one cycle after idx 7 is serviced.
